sumdiff_block_accum: RTL and testbench

Downstream consumer of the 8-bit adder/subtractor datapath. It takes paired `sum`/`diff` results over a valid/ready handshake and accumulates them over a block of `BLOCK_LEN` samples, or fewer if flushed. It then presents the block totals and sample count on a registered valid/ready output port. This stage turns per-cycle arithmetic results into block-level statistics for the next stage.

---
 rtl/sumdiff_block_accum_if.sv | 30 +++
 rtl/sumdiff_block_accum.sv | 148 ++++++++++++++
 tb/tb_sumdiff_block_accum.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sumdiff_block_accum_if.sv
// Handshake bundle between the sum/diff producer, the block accumulator and its consumer.
// master = upstream/downstream side, slave = the accumulator itself.
interface sumdiff_block_accum_if #(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 12,
   parameter int BLOCK_LEN = 4,
   localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
);
   logic                     in_valid;
   logic                     in_ready;
   logic        [DATA_W-1:0] in_sum;
   logic signed [DATA_W-1:0] in_diff;
   logic                     flush;
   logic                     out_valid;
   logic                     out_ready;
   logic        [ACC_W-1:0]  out_sum;
   logic signed [ACC_W-1:0]  out_diff;
   logic        [CNT_W-1:0]  out_count;
   logic                     out_ovf;

   modport master (
      output in_valid, in_sum, in_diff, flush, out_ready,
      input  in_ready, out_valid, out_sum, out_diff, out_count, out_ovf
   );

   modport slave (
      input  in_valid, in_sum, in_diff, flush, out_ready,
      output in_ready, out_valid, out_sum, out_diff, out_count, out_ovf
   );
endinterface

// File: rtl/sumdiff_block_accum.sv
// Accumulates sum/diff samples into blocks of BLOCK_LEN (or fewer on flush) and holds the totals.
// Optional feature macro SUMDIFF_ACCUM_SAT_EN: saturating accumulation with sticky out_ovf.
module sumdiff_block_accum #(
   parameter int DATA_W    = 8,
   parameter int ACC_W     = 12,
   parameter int BLOCK_LEN = 4,
   localparam int CNT_W    = $clog2(BLOCK_LEN + 1)
) (
   input logic                 clk,
   input logic                 rst,
   sumdiff_block_accum_if.slave bus
);

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BLOCK_LEN - 1);

   state_t                   state_q, state_d;
   logic        [ACC_W-1:0]  acc_sum_q, acc_sum_d;
   logic signed [ACC_W-1:0]  acc_diff_q, acc_diff_d;
   logic        [CNT_W-1:0]  cnt_q, cnt_d;

   logic                     accept;
   logic                     close_blk;
   logic        [ACC_W-1:0]  sum_ext;
   logic signed [ACC_W-1:0]  diff_ext;
   logic        [ACC_W-1:0]  sum_n;
   logic signed [ACC_W-1:0]  diff_n;

`ifdef SUMDIFF_ACCUM_SAT_EN
   logic ovf_q, ovf_d;
   logic ovf_sum, ovf_diff;

   // Result is {clamped, value}; value pinned to all-ones on unsigned carry-out.
   function automatic logic [ACC_W:0] sat_add_u(input logic [ACC_W-1:0] a,
                                                input logic [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {1'b0, a} + {1'b0, b};
      if (s[ACC_W]) return {1'b1, {ACC_W{1'b1}}};
      return {1'b0, s[ACC_W-1:0]};
   endfunction

   function automatic logic [ACC_W:0] sat_add_s(input logic signed [ACC_W-1:0] a,
                                                input logic signed [ACC_W-1:0] b);
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1]) begin
         if (s[ACC_W]) return {2'b11, {(ACC_W-1){1'b0}}};
         return {2'b10, {(ACC_W-1){1'b1}}};
      end
      return {1'b0, s[ACC_W-1:0]};
   endfunction
`else
   function automatic logic [ACC_W-1:0] wrap_add_u(input logic [ACC_W-1:0] a,
                                                   input logic [ACC_W-1:0] b);
      return a + b;
   endfunction

   function automatic logic signed [ACC_W-1:0] wrap_add_s(input logic signed [ACC_W-1:0] a,
                                                          input logic signed [ACC_W-1:0] b);
      return a + b;
   endfunction
`endif

   assign sum_ext  = {{(ACC_W-DATA_W){1'b0}}, bus.in_sum};
   assign diff_ext = {{(ACC_W-DATA_W){bus.in_diff[DATA_W-1]}}, bus.in_diff};
   assign accept   = bus.in_valid && (state_q == ACCUM);
   // A flush closes the block only if it holds something, counting a sample accepted this cycle.
   assign close_blk = (accept && (cnt_q == LAST_CNT)) ||
                      (bus.flush && ((cnt_q != '0) || accept));

   always_comb begin
`ifdef SUMDIFF_ACCUM_SAT_EN
      {ovf_sum,  sum_n}  = sat_add_u(acc_sum_q, sum_ext);
      {ovf_diff, diff_n} = sat_add_s(acc_diff_q, diff_ext);
`else
      sum_n  = wrap_add_u(acc_sum_q, sum_ext);
      diff_n = wrap_add_s(acc_diff_q, diff_ext);
`endif
   end

   always_comb begin
      state_d    = state_q;
      acc_sum_d  = acc_sum_q;
      acc_diff_d = acc_diff_q;
      cnt_d      = cnt_q;
`ifdef SUMDIFF_ACCUM_SAT_EN
      ovf_d      = ovf_q;
`endif
      case (state_q)
         ACCUM: begin
            if (accept) begin
               acc_sum_d  = sum_n;
               acc_diff_d = diff_n;
               cnt_d      = cnt_q + CNT_W'(1);
`ifdef SUMDIFF_ACCUM_SAT_EN
               ovf_d      = ovf_q | ovf_sum | ovf_diff;
`endif
            end
            if (close_blk) state_d = HOLD;
         end
         HOLD: begin
            if (bus.out_ready) begin
               state_d    = ACCUM;
               acc_sum_d  = '0;
               acc_diff_d = '0;
               cnt_d      = '0;
`ifdef SUMDIFF_ACCUM_SAT_EN
               ovf_d      = 1'b0;
`endif
            end
         end
         default: state_d = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ACCUM;
         acc_sum_q  <= '0;
         acc_diff_q <= '0;
         cnt_q      <= '0;
`ifdef SUMDIFF_ACCUM_SAT_EN
         ovf_q      <= 1'b0;
`endif
      end else begin
         state_q    <= state_d;
         acc_sum_q  <= acc_sum_d;
         acc_diff_q <= acc_diff_d;
         cnt_q      <= cnt_d;
`ifdef SUMDIFF_ACCUM_SAT_EN
         ovf_q      <= ovf_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == ACCUM);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.out_sum   = acc_sum_q;
   assign bus.out_diff  = acc_diff_q;
   assign bus.out_count = cnt_q;
`ifdef SUMDIFF_ACCUM_SAT_EN
   assign bus.out_ovf   = ovf_q;
`else
   assign bus.out_ovf   = 1'b0;
`endif

endmodule

// File: tb/tb_sumdiff_block_accum.sv
// Self-checking bench for sumdiff_block_accum: directed scenarios plus randomized blocks
// compared against an integer-arithmetic block model (default ACC_W=12 and a narrow ACC_W=9 copy).
module tb_sumdiff_block_accum;

   logic clk = 1'b0;
   logic rst;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   sumdiff_block_accum_if #(.DATA_W(8), .ACC_W(12), .BLOCK_LEN(4)) bus  ();
   sumdiff_block_accum_if #(.DATA_W(8), .ACC_W(9),  .BLOCK_LEN(4)) bus9 ();

   sumdiff_block_accum #(.DATA_W(8), .ACC_W(12), .BLOCK_LEN(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   sumdiff_block_accum #(.DATA_W(8), .ACC_W(9), .BLOCK_LEN(4)) dut9 (
      .clk (clk),
      .rst (rst),
      .bus (bus9)
   );

   // Block totals from plain integer arithmetic; returns low ACC_W bits of the expected results.
   function automatic void model(input int sums[$], input int diffs[$], input int w,
                                 output logic [11:0] es, output logic [11:0] ed,
                                 output logic eo);
      longint s, d, maxu, maxs, mins, m;
      s = 0; d = 0; eo = 1'b0;
      m    = longint'(1) << w;
      maxu = m - 1;
      maxs = (m / 2) - 1;
      mins = -(m / 2);
      foreach (sums[i]) begin
         s += sums[i];
         d += diffs[i];
`ifdef SUMDIFF_ACCUM_SAT_EN
         if (s > maxu) begin s = maxu; eo = 1'b1; end
         if (d > maxs) begin d = maxs; eo = 1'b1; end
         if (d < mins) begin d = mins; eo = 1'b1; end
`else
         s = s % m;
         d = ((d % m) + m) % m;
`endif
      end
      es = 12'(s & maxu);
      ed = 12'(d & maxu);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one sample (optionally with flush) until it is accepted, then drops in_valid.
   task automatic drive(input logic [7:0] s, input logic [7:0] d, input logic f);
      int guard;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_sum   = s;
      bus.in_diff  = d;
      bus.flush    = f;
      while (!bus.in_ready && guard < 50) begin
         tick();
         guard++;
      end
      if (guard >= 50) begin
         checks++; errors++;
         $display("FAIL drive_timeout: in_ready stayed %b, required 1", bus.in_ready);
      end
      tick();
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
   endtask

   task automatic check_block(input string name, input logic [11:0] es, input logic [11:0] ed,
                              input logic [2:0] ec, input logic eo);
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
         errors++;
         $display("FAIL %s_valid: out_valid=%b in_ready=%b, required 1/0", name, bus.out_valid, bus.in_ready);
      end
      checks++;
      if (bus.out_sum !== es || bus.out_diff !== ed) begin
         errors++;
         $display("FAIL %s_totals: sum=%0d diff=%h, required sum=%0d diff=%h", name, bus.out_sum, bus.out_diff, es, ed);
      end
      checks++;
      if (bus.out_count !== ec || bus.out_ovf !== eo) begin
         errors++;
         $display("FAIL %s_count: count=%0d ovf=%b, required count=%0d ovf=%b", name, bus.out_count, bus.out_ovf, ec, eo);
      end
   endtask

   task automatic release_block(input string name);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_count !== 3'd0 || bus.out_sum !== 12'd0) begin
         errors++;
         $display("FAIL %s_release: out_valid=%b in_ready=%b count=%0d sum=%0d, required 0/1/0/0", name, bus.out_valid, bus.in_ready, bus.out_count, bus.out_sum);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      checks++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_sum !== 12'd0 ||
          bus.out_diff !== 12'd0 || bus.out_count !== 3'd0 || bus.out_ovf !== 1'b0) begin
         errors++;
         $display("FAIL reset: rdy=%b vld=%b sum=%0d diff=%0d cnt=%0d ovf=%b, required 1/0/0/0/0/0", bus.in_ready, bus.out_valid, bus.out_sum, bus.out_diff, bus.out_count, bus.out_ovf);
      end
      checks++;
      if (bus9.in_ready !== 1'b1 || bus9.out_valid !== 1'b0 || bus9.out_sum !== 9'd0 || bus9.out_diff !== 9'd0) begin
         errors++;
         $display("FAIL reset9: rdy=%b vld=%b sum=%0d diff=%0d, required 1/0/0/0", bus9.in_ready, bus9.out_valid, bus9.out_sum, bus9.out_diff);
      end
   endtask

   task automatic test_full_block();
      bus.out_ready = 1'b0;
      drive(8'd10, 8'h01, 1'b0);
      drive(8'd20, 8'hFE, 1'b0);
      drive(8'd30, 8'h03, 1'b0);
      checks++;
      if (bus.out_valid !== 1'b0) begin
         errors++;
         $display("FAIL full_early_valid: out_valid=%b after 3 samples, required 0", bus.out_valid);
      end
      drive(8'd40, 8'hFC, 1'b0);
      check_block("full", 12'd100, 12'hFFE, 3'd4, 1'b0);
   endtask

   task automatic test_back_to_back();
      int sq[$], dq[$];
      logic [11:0] es, ed;
      logic eo;
      // Result from test_full_block is still held; backpressure with a pending sample and flush.
      bus.in_valid = 1'b1;
      bus.in_sum   = 8'd99;
      bus.in_diff  = 8'h55;
      for (int i = 0; i < 5; i++) begin
         bus.flush = i[0];
         tick();
         check_block("backpressure", 12'd100, 12'hFFE, 3'd4, 1'b0);
      end
      bus.in_valid = 1'b0;
      bus.flush    = 1'b0;
      release_block("backpressure");
      for (int i = 1; i <= 4; i++) begin
         sq.push_back(i);
         dq.push_back(-i);
         drive(8'(i), 8'(-i), 1'b0);
      end
      model(sq, dq, 12, es, ed, eo);
      check_block("after_bp", es, ed, 3'd4, eo);
      release_block("after_bp");
   endtask

   task automatic test_flush();
      drive(8'd5, 8'h00, 1'b0);
      drive(8'd7, 8'h00, 1'b0);
      drive(8'd9, 8'h00, 1'b1);
      check_block("flush_with_sample", 12'd21, 12'd0, 3'd3, 1'b0);
      release_block("flush_with_sample");
      bus.flush = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_empty: out_valid=%b, required 0", bus.out_valid);
         end
      end
      bus.flush = 1'b0;
      // A lone flush after samples closes the block on its own.
      drive(8'd3, 8'hFF, 1'b0);
      bus.flush = 1'b1;
      tick();
      bus.flush = 1'b0;
      check_block("flush_alone", 12'd3, 12'hFFF, 3'd1, 1'b0);
      release_block("flush_alone");
   endtask

   task automatic test_overflow();
      int sq[$], dq[$];
      logic [11:0] es, ed;
      logic eo;
      int guard;
      bus9.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         sq.push_back(255);
         dq.push_back(-128);
         bus9.in_valid = 1'b1;
         bus9.in_sum   = 8'd255;
         bus9.in_diff  = 8'h80;
         guard = 0;
         while (!bus9.in_ready && guard < 20) begin tick(); guard++; end
         tick();
      end
      bus9.in_valid = 1'b0;
      model(sq, dq, 9, es, ed, eo);
      checks++;
      if (bus9.out_valid !== 1'b1 || bus9.out_sum !== es[8:0] || bus9.out_diff !== ed[8:0] ||
          bus9.out_ovf !== eo || bus9.out_count !== 3'd4) begin
         errors++;
         $display("FAIL overflow9: vld=%b sum=%0d diff=%h ovf=%b cnt=%0d, required 1/%0d/%h/%b/4", bus9.out_valid, bus9.out_sum, bus9.out_diff, bus9.out_ovf, bus9.out_count, es[8:0], ed[8:0], eo);
      end
      bus9.out_ready = 1'b1;
      tick();
      checks++;
      if (bus9.out_valid !== 1'b0 || bus9.out_ovf !== 1'b0 || bus9.out_sum !== 9'd0) begin
         errors++;
         $display("FAIL overflow9_clear: vld=%b ovf=%b sum=%0d, required 0/0/0", bus9.out_valid, bus9.out_ovf, bus9.out_sum);
      end
   endtask

   task automatic test_reset_mid_block();
      int sq[$], dq[$];
      logic [11:0] es, ed;
      logic eo;
      drive(8'd50, 8'h10, 1'b0);
      drive(8'd60, 8'h20, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.out_sum !== 12'd0 || bus.out_count !== 3'd0 || bus.in_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_mid: sum=%0d cnt=%0d rdy=%b, required 0/0/1", bus.out_sum, bus.out_count, bus.in_ready);
      end
      for (int i = 0; i < 4; i++) begin
         sq.push_back(1);
         dq.push_back(2);
         drive(8'd1, 8'd2, 1'b0);
      end
      model(sq, dq, 12, es, ed, eo);
      check_block("reset_mid", es, ed, 3'd4, eo);
      // Reset while holding a result discards it.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (bus.out_valid !== 1'b0 || bus.out_sum !== 12'd0 || bus.out_count !== 3'd0) begin
         errors++;
         $display("FAIL reset_hold: vld=%b sum=%0d cnt=%0d, required 0/0/0", bus.out_valid, bus.out_sum, bus.out_count);
      end
   endtask

   task automatic test_random_blocks();
      int sq[$], dq[$];
      logic [11:0] es, ed;
      logic eo;
      int len, mode, hold;
      logic [7:0] s8, d8;
      logic fl;
      for (int blk = 0; blk < 30; blk++) begin
         sq.delete();
         dq.delete();
         len  = $urandom_range(1, 4);
         mode = $urandom_range(0, 1);
         bus.out_ready = 1'b0;
         for (int i = 0; i < len; i++) begin
            s8 = 8'($urandom);
            d8 = 8'($urandom);
            sq.push_back(int'(s8));
            dq.push_back(int'($signed(d8)));
            fl = (len < 4) && (i == len - 1) && (mode == 0);
            repeat ($urandom_range(0, 2)) tick();
            drive(s8, d8, fl);
         end
         if (len < 4 && mode == 1) begin
            bus.flush = 1'b1;
            tick();
            bus.flush = 1'b0;
         end
         model(sq, dq, 12, es, ed, eo);
         check_block("random", es, ed, 3'(len), eo);
         hold = $urandom_range(0, 3);
         for (int h = 0; h < hold; h++) begin
            bus.in_valid = 1'b1;
            bus.in_sum   = 8'($urandom);
            tick();
            bus.in_valid = 1'b0;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_sum !== es || bus.out_diff !== ed) begin
               errors++;
               $display("FAIL random_hold: vld=%b sum=%0d diff=%h, required 1/%0d/%h", bus.out_valid, bus.out_sum, bus.out_diff, es, ed);
            end
         end
         release_block("random");
      end
   endtask

   initial begin
      rst            = 1'b1;
      bus.in_valid   = 1'b0;
      bus.in_sum     = '0;
      bus.in_diff    = '0;
      bus.flush      = 1'b0;
      bus.out_ready  = 1'b0;
      bus9.in_valid  = 1'b0;
      bus9.in_sum    = '0;
      bus9.in_diff   = '0;
      bus9.flush     = 1'b0;
      bus9.out_ready = 1'b1;
      test_reset();
      test_full_block();
      test_back_to_back();
      test_flush();
      test_overflow();
      test_reset_mid_block();
      test_random_blocks();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
